// File: rtl/program_memory_loader.sv
// program_memory_loader
//   Byte-stream bootloader. Receives a 16-bit little-endian word count followed
//   by that many little-endian 32-bit words on a valid/ready byte interface.
//   It writes each word to program memory at BASE_ADDRESS + 4*index, and holds
//   the CPU in reset until a load completes cleanly.
//
//   Optional feature: define LOADER_CHECKSUM_EN to append one checksum byte
//   after the last word. The checksum is the XOR of every preceding stream
//   byte, length bytes included. A mismatch ends the load in ERROR, but the
//   memory writes already issued are kept.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   Start         begin a load (honoured in IDLE, DONE and ERROR only)
//   ByteIn        stream byte
//   ByteValid     ByteIn valid
//   ByteReady     loader accepts a byte this cycle
//   WriteEnable   one-cycle program memory write strobe
//   WriteAddress  byte address of the word being written
//   WriteData     assembled word
//   WordCount     length field of the current or last load
//   Busy          load in progress
//   Done          last load completed without error
//   Error         last load aborted
//   CpuReset      CPU reset, low only while Done is high
//
// The word assembly is built from four byte lanes, so DATA_WIDTH must be at least 32.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | after reset, waiting for Start
// LEN_LO  | expecting low byte of the word count
// LEN_HI  | expecting high byte of the word count, then range check
// DATA    | assembling a word, one byte lane per accepted byte
// WRITE   | single-cycle write strobe for the assembled word
// CHECK   | (checksum build only) expecting the checksum byte
// DONE    | load succeeded, CPU released
// ERROR   | load rejected or checksum mismatch, CPU held in reset

module program_memory_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [15:0]           WordCount,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  CpuReset
);

    localparam int          IDX_W       = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [15:0] DEPTH_LIMIT = 16'(MEMORY_DEPTH);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        index_q;
    logic [1:0]              lane_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [15:0]             count_q;
    logic [15:0]             len_next;
    logic                    last_word;
    logic                    byte_xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              xor_q;
`endif

    assign byte_xfer = ByteValid && ByteReady;
    assign len_next  = {ByteIn, count_q[7:0]};
    // Compare index+1 against the count so that index itself never has to
    // hold the value MEMORY_DEPTH.
    assign last_word = ((16'(index_q) + 16'd1) == count_q);

    assign WriteAddress = BASE_ADDRESS + DATA_WIDTH'({index_q, 2'b00});
    assign WriteData    = word_q;
    assign WordCount    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ByteReady   = 1'b0;
        WriteEnable = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        Error       = 1'b0;
        CpuReset    = 1'b1;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) begin
                    if (len_next == 16'd0 || len_next > DEPTH_LIMIT) state_next = S_ERROR;
                    else                                              state_next = S_DATA;
                end
            end
            S_DATA: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid && lane_q == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                WriteEnable = 1'b1;
                Busy        = 1'b1;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (ByteValid) state_next = (xor_q == ByteIn) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                Done     = 1'b1;
                CpuReset = 1'b0;
                if (Start) state_next = S_LEN_LO;
            end
            S_ERROR: begin
                Error = 1'b1;
                if (Start) state_next = S_LEN_LO;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
            lane_q  <= 2'd0;
            word_q  <= '0;
            count_q <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        index_q <= '0;
                        lane_q  <= 2'd0;
                    end
                end
                S_LEN_LO: begin
                    if (ByteValid) count_q[7:0] <= ByteIn;
                end
                S_LEN_HI: begin
                    if (ByteValid) count_q[15:8] <= ByteIn;
                end
                S_DATA: begin
                    if (ByteValid) begin
                        case (lane_q)
                            2'd0:    word_q[7:0]   <= ByteIn;
                            2'd1:    word_q[15:8]  <= ByteIn;
                            2'd2:    word_q[23:16] <= ByteIn;
                            default: word_q[31:24] <= ByteIn;
                        endcase
                        // Wraps to lane 0 after the fourth byte.
                        lane_q <= lane_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!last_word) index_q <= index_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= 8'd0;
        end else if ((state == S_IDLE || state == S_DONE || state == S_ERROR) && Start) begin
            xor_q <= 8'd0;
        end else if (byte_xfer) begin
            xor_q <= xor_q ^ ByteIn;
        end
    end
`else
    // byte_xfer is only needed for the running XOR of the checksum build.
    logic unused_xfer;
    assign unused_xfer = byte_xfer;
`endif

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed testbench for program_memory_loader.
module tb_program_memory_loader;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic [15:0] WordCount;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic        CpuReset;

    int          checks = 0;
    int          errors = 0;
    int          ready_in_write = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  tb_xor;

    logic [7:0]  stream1 [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int          gaps1   [10] = '{0, 1, 0, 0, 2, 0, 0, 1, 0, 3};

    program_memory_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .WordCount    (WordCount),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .CpuReset     (CpuReset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (WriteEnable) begin
            wr_q.push_back({WriteAddress, WriteData});
            if (ByteReady) ready_in_write++;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start  = 1'b0;
        tb_xor = 8'h00;
    endtask

    // Presents a byte and returns #1 after the edge that accepted it.
    // ByteValid is left high so back-to-back bytes need no idle cycle.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ByteIn    = b;
        ByteValid = 1'b1;
        @(negedge clk);
        while (!ByteReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ByteReady) begin
            check("byte_ready_timeout", 32'(ByteReady), 32'd1);
            ByteValid = 1'b0;
        end else begin
            @(posedge clk); #1;
            tb_xor = tb_xor ^ b;
        end
    endtask

    // Closes a load after its last word: checksum byte when enabled,
    // otherwise just lets the WRITE cycle finish. Ends in DONE.
    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor);
        ByteValid = 1'b0;
`else
        ByteValid = 1'b0;
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        reset     = 1'b1;
        Start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        tb_xor    = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_busy",   32'(Busy),        32'd0);
        check("rst_done",   32'(Done),        32'd0);
        check("rst_error",  32'(Error),       32'd0);
        check("rst_cpurst", 32'(CpuReset),    32'd1);
        check("rst_we",     32'(WriteEnable), 32'd0);
        check("rst_ready",  32'(ByteReady),   32'd0);
        check("rst_addr",   WriteAddress,     32'h0040_0000);
        check("rst_data",   WriteData,        32'h0);
        check("rst_count",  32'(WordCount),   32'd0);

        // Test 1: two-word load
        wr_q.delete();
        do_start();
        check("t1_busy",  32'(Busy),      32'd1);
        check("t1_ready", 32'(ByteReady), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        check("t1_count", 32'(WordCount), 32'd2);
        ByteValid = 1'b0;
        // Start while busy must be ignored.
        do_start();
        check("t1_busy_ignore", 32'(Busy), 32'd1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        check("t1_we0",    32'(WriteEnable), 32'd1);
        check("t1_ready0", 32'(ByteReady),   32'd0);
        check("t1_addr0",  WriteAddress,     32'h0040_0000);
        check("t1_data0",  WriteData,        32'h1234_5678);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        check("t1_we1",   32'(WriteEnable), 32'd1);
        check("t1_addr1", WriteAddress,     32'h0040_0004);
        check("t1_data1", WriteData,        32'hDEAD_BEEF);
        finish_load();
        check("t1_done",   32'(Done),      32'd1);
        check("t1_cpurst", 32'(CpuReset),  32'd0);
        check("t1_busy2",  32'(Busy),      32'd0);
        check("t1_nwr",    32'(wr_q.size()), 32'd2);

        // Test 2: zero length
        wr_q.delete();
        do_start();
        check("t2_done_clr", 32'(Done),     32'd0);
        check("t2_cpurst",   32'(CpuReset), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        ByteValid = 1'b0;
        check("t2_error",  32'(Error),     32'd1);
        check("t2_cpurst2",32'(CpuReset),  32'd1);
        check("t2_busy",   32'(Busy),      32'd0);
        check("t2_ready",  32'(ByteReady), 32'd0);
        do_start();
        check("t2_err_clr", 32'(Error), 32'd0);

        // Test 3: length 33 > depth
        send_byte(8'h21);
        send_byte(8'h00);
        ByteValid = 1'b0;
        check("t3_error", 32'(Error),     32'd1);
        check("t3_count", 32'(WordCount), 32'h21);
        check("t3_nwr",   32'(wr_q.size()), 32'd0);

        // Length equal to depth is accepted and fills every word.
        wr_q.delete();
        do_start();
        send_byte(8'h20);
        send_byte(8'h00);
        check("tmax_error", 32'(Error), 32'd0);
        check("tmax_busy",  32'(Busy),  32'd1);
        for (int i = 0; i < 128; i++) send_byte(8'(i));
        finish_load();
        check("tmax_done", 32'(Done),        32'd1);
        check("tmax_nwr",  32'(wr_q.size()), 32'd32);
        for (int w = 0; w < 32 && w < wr_q.size(); w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            check($sformatf("tmax_addr%0d", w), wr_q[w][63:32], 32'h0040_0000 + 32'(4 * w));
            check($sformatf("tmax_data%0d", w), wr_q[w][31:0],
                  {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end

        // Test 4: gaps and ByteValid held through WRITE
        wr_q.delete();
        do_start();
        for (int i = 0; i < 10; i++) begin
            if (gaps1[i] > 0) begin
                ByteValid = 1'b0;
                repeat (gaps1[i]) @(posedge clk);
                #1;
            end
            send_byte(stream1[i]);
        end
        finish_load();
        check("t4_done", 32'(Done),        32'd1);
        check("t4_nwr",  32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("t4_addr0", wr_q[0][63:32], 32'h0040_0000);
            check("t4_data0", wr_q[0][31:0],  32'h1234_5678);
            check("t4_addr1", wr_q[1][63:32], 32'h0040_0004);
            check("t4_data1", wr_q[1][31:0],  32'hDEAD_BEEF);
        end
        check("t4_ready_in_write", 32'(ready_in_write), 32'd0);

        // Test 5: reset mid-load
        wr_q.delete();
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        ByteValid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_rst_busy",   32'(Busy),      32'd0);
        check("t5_rst_cpurst", 32'(CpuReset),  32'd1);
        check("t5_rst_count",  32'(WordCount), 32'd0);
        check("t5_rst_data",   WriteData,      32'h0);
        check("t5_rst_ready",  32'(ByteReady), 32'd0);
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("t5_we",   32'(WriteEnable), 32'd1);
        check("t5_addr", WriteAddress,     32'h0040_0000);
        check("t5_data", WriteData,        32'h4433_2211);
        finish_load();
        check("t5_done", 32'(Done),        32'd1);
        check("t5_nwr",  32'(wr_q.size()), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Test 6: checksum match and mismatch
        wr_q.delete();
        do_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t6a_data", WriteData, 32'h0000_0001);
        send_byte(8'h00);
        ByteValid = 1'b0;
        check("t6a_done", 32'(Done), 32'd1);
        wr_q.delete();
        do_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hFF);
        ByteValid = 1'b0;
        check("t6b_error",  32'(Error),       32'd1);
        check("t6b_cpurst", 32'(CpuReset),    32'd1);
        check("t6b_nwr",    32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("t6b_wdata", wr_q[0][31:0], 32'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
